// File: rtl/vend_acceptor_if.sv
// Coin-acceptor customer-side bundle: coin/cancel strobes in,
// credit, vend/refund pulses and counters out.
interface vend_acceptor_if #(
    parameter int DW    = 7,
    parameter int CNT_W = 16
);
    logic             nickel_i;
    logic             dime_i;
    logic             quarter_i;
    logic             cancel_i;
    logic [DW-1:0]    deposit_o;
    logic             dispense_o;
    logic             refund_o;
    logic [DW-1:0]    change_o;
    logic             coin_err_o;
    logic [CNT_W-1:0] vend_count_o;

    modport master (
        output nickel_i, dime_i, quarter_i, cancel_i,
        input  deposit_o, dispense_o, refund_o,
        input  change_o, coin_err_o, vend_count_o
    );

    modport slave (
        input  nickel_i, dime_i, quarter_i, cancel_i,
        output deposit_o, dispense_o, refund_o,
        output change_o, coin_err_o, vend_count_o
    );
endinterface

// File: rtl/vend_acceptor.sv
// Vending coin acceptor: accumulates credit, vends at PRICE with change,
// refunds on cancel or after TIMEOUT idle cycles in credit.
module vend_acceptor #(
    parameter int PRICE       = 20,
    parameter int NICKEL_VAL  = 5,
    parameter int DIME_VAL    = 10,
    parameter int QUARTER_VAL = 25,
    parameter int DW          = 7,
    parameter int TIMEOUT     = 1000,
    parameter int CNT_W       = 16
) (
    input logic            clk_i,
    input logic            rst_i,
    vend_acceptor_if.slave bus
);
    localparam int TW = $clog2(TIMEOUT);

    if (PRICE + QUARTER_VAL - 1 >= 2 ** DW) begin : g_dw_chk
        $error("vend_acceptor: DW too narrow for PRICE+QUARTER_VAL-1");
    end
    if (PRICE <= 0) begin : g_price_chk
        $error("vend_acceptor: PRICE must be positive");
    end
    if (TIMEOUT < 2) begin : g_to_chk
        $error("vend_acceptor: TIMEOUT must be at least 2");
    end

    typedef enum logic [1:0] {
        IDLE,
        CREDIT,
        VEND,
        REFUND
    } state_t;

    state_t           state_q, state_d;
    logic [DW-1:0]    deposit_q, deposit_d;
    logic [DW-1:0]    change_q, change_d;
    logic             disp_q, disp_d;
    logic             refund_q, refund_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [TW-1:0]    timer_q, timer_d;

    logic [1:0]       n_coins;
    logic             coin_ok;
    logic [DW-1:0]    coin_val;
    logic [DW-1:0]    sum;
    logic             idle_credit;

    // Decode coin strobes and compute the next-state/output bundle
    always_comb begin
        n_coins = {1'b0, bus.nickel_i} + {1'b0, bus.dime_i}
                + {1'b0, bus.quarter_i};
        coin_ok = (n_coins == 2'd1);
        coin_val = '0;
        if (coin_ok) begin
            unique case (1'b1)
                bus.nickel_i:  coin_val = DW'(NICKEL_VAL);
                bus.dime_i:    coin_val = DW'(DIME_VAL);
                bus.quarter_i: coin_val = DW'(QUARTER_VAL);
                default:       coin_val = '0;
            endcase
        end
        sum = deposit_q + coin_val;
        idle_credit = (state_q == CREDIT) && !coin_ok && !bus.cancel_i;

        state_d   = IDLE;
        deposit_d = '0;
        change_d  = '0;
        disp_d    = 1'b0;
        refund_d  = 1'b0;
        err_d     = (n_coins > 2'd1);
        cnt_d     = cnt_q;

        if (bus.cancel_i && sum != '0) begin
            state_d  = REFUND;
            refund_d = 1'b1;
            change_d = sum;
        end else if (idle_credit && timer_q == TW'(TIMEOUT - 1)) begin
            state_d  = REFUND;
            refund_d = 1'b1;
            change_d = deposit_q;
        end else if (sum >= DW'(PRICE)) begin
            state_d  = VEND;
            disp_d   = 1'b1;
            change_d = sum - DW'(PRICE);
            cnt_d    = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
        end else if (sum != '0) begin
            state_d   = CREDIT;
            deposit_d = sum;
        end

        // Only a coinless cycle that stays in credit advances the timer
        timer_d = (state_d == CREDIT && !coin_ok) ? timer_q + 1'b1 : '0;
    end

    // State and registered outputs, synchronous reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            deposit_q <= '0;
            change_q  <= '0;
            disp_q    <= 1'b0;
            refund_q  <= 1'b0;
            err_q     <= 1'b0;
            cnt_q     <= '0;
            timer_q   <= '0;
        end else begin
            state_q   <= state_d;
            deposit_q <= deposit_d;
            change_q  <= change_d;
            disp_q    <= disp_d;
            refund_q  <= refund_d;
            err_q     <= err_d;
            cnt_q     <= cnt_d;
            timer_q   <= timer_d;
        end
    end

    assign bus.deposit_o    = deposit_q;
    assign bus.change_o     = change_q;
    assign bus.dispense_o   = disp_q;
    assign bus.refund_o     = refund_q;
    assign bus.coin_err_o   = err_q;
    assign bus.vend_count_o = cnt_q;
endmodule
